// File: rtl/seg_scan.sv
// Time-multiplexed 4-digit common-anode seven-segment scanner with per-slot anti-ghosting blank.
// Optional leading-zero blanking: define SEG_SCAN_LEADING_ZERO_BLANK_EN.
module seg_scan #(
    parameter int CLK_DIV = 50000,
    parameter int DEAD    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] digit,
    input  logic [3:0] dp_mask,
    output logic [1:0] index,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_done
);

    localparam int unsigned CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] LOAD_AT  = CW'(DEAD - 1);
    localparam logic [CW-1:0] SHOW_AT  = CW'(DEAD);

    typedef enum logic {S_DEAD, S_SHOW} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [1:0]    index_nx;
    logic [3:0]    an_nx;
    logic [6:0]    seg_nx;
    logic          load, wrap;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h40;
            4'd1:    decode = 7'h79;
            4'd2:    decode = 7'h24;
            4'd3:    decode = 7'h30;
            4'd4:    decode = 7'h19;
            4'd5:    decode = 7'h12;
            4'd6:    decode = 7'h02;
            4'd7:    decode = 7'h78;
            4'd8:    decode = 7'h00;
            4'd9:    decode = 7'h10;
            default: decode = 7'h3F;
        endcase
    endfunction

    // Anode pattern is computed from the next count/index so the registered
    // output lines up with the cycle in which cnt holds that value.
    always_comb begin
        cnt_nx   = '0;
        index_nx = index;
        state_nx = S_DEAD;
        an_nx    = '1;
        wrap     = 1'b0;
        load     = 1'b0;
        if (en) begin
            load = (state == S_DEAD) && (cnt == LOAD_AT);
            if (cnt == CNT_LAST) begin
                wrap     = 1'b1;
                index_nx = index + 2'd1;
            end else begin
                cnt_nx = cnt + CW'(1);
            end
            if (cnt_nx >= SHOW_AT)
                state_nx = S_SHOW;
        end
        if (state_nx == S_SHOW)
            an_nx = ~(4'b1000 >> index_nx);
    end

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
    logic nz, nz_cur, nz_nx;

    // The thousands load starts a new number, so the flag is ignored there.
    always_comb begin
        nz_cur = (index == 2'd0) ? 1'b0 : nz;
        nz_nx  = nz_cur | (digit != 4'd0);
        seg_nx = decode(digit);
        if (!nz_cur && digit == 4'd0 && index != 2'd3)
            seg_nx = '1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            nz <= 1'b0;
        else if (load)
            nz <= nz_nx;
    end
`else
    always_comb begin
        seg_nx = decode(digit);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_DEAD;
            cnt        <= '0;
            index      <= '0;
            an         <= '1;
            seg        <= '1;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            index      <= index_nx;
            an         <= an_nx;
            frame_done <= wrap && (index == 2'd3);
            if (load) begin
                seg <= seg_nx;
                dp  <= ~dp_mask[index];
            end
        end
    end

endmodule

// File: tb/tb_seg_scan.sv
// Scoreboard bench for seg_scan: per-slot expectations queued with the stimulus, checked cycle by cycle.
// Expectations for blanking follow SEG_SCAN_LEADING_ZERO_BLANK_EN.
module tb_seg_scan;

    localparam int CLK_DIV = 8;
    localparam int DEAD    = 2;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst, en;
    logic [3:0] digit, dp_mask;
    logic [1:0] index;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp, frame_done;

    logic [3:0] val [4];
    exp_t       q [$];
    int         vectors = 0;
    int         miscompares = 0;
    logic [6:0] prev_seg;
    logic       prev_dp;
    bit         frame_seen;

    always #5 clk = ~clk;

    // Stand-in for the digit extractor: combinational lookup on index.
    assign digit = val[index];

    seg_scan #(.CLK_DIV(CLK_DIV), .DEAD(DEAD)) dut (
        .clk(clk), .rst(rst), .en(en), .digit(digit), .dp_mask(dp_mask),
        .index(index), .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_number(input logic [3:0] d0, d1, d2, d3);
        val[0] = d0; val[1] = d1; val[2] = d2; val[3] = d3;
    endtask

    task automatic push_frame(input logic [6:0] s0, s1, s2, s3, input logic [3:0] dpm);
        logic [6:0] segs [4];
        logic [3:0] one;
        exp_t e;
        segs[0] = s0; segs[1] = s1; segs[2] = s2; segs[3] = s3;
        one = 4'b1000;
        for (int i = 0; i < 4; i++) begin
            e.an  = ~(one >> i);
            e.seg = segs[i];
            e.dp  = ~dpm[i];
            q.push_back(e);
        end
    endtask

    task automatic check_reset_values(input string name);
        vectors++;
        if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || index !== 2'd0 || frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL %s: got an=%h seg=%h dp=%b index=%0d fd=%b, expected an=f seg=7f dp=1 index=0 fd=0",
                     name, an, seg, dp, index, frame_done);
        end
    endtask

    task automatic check_slot(input int s);
        exp_t       e;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_dp, exp_fd;
        if (q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard slot%0d: got 0 queued entries, expected 1", s);
            e = '{an: 4'hF, seg: 7'h7F, dp: 1'b1};
        end else begin
            e = q.pop_front();
        end
        for (int c = 0; c < CLK_DIV; c++) begin
            exp_fd = (s == 0 && c == 0 && frame_seen);
            if (c < DEAD) begin
                exp_an = 4'hF; exp_seg = prev_seg; exp_dp = prev_dp;
            end else begin
                exp_an = e.an; exp_seg = e.seg; exp_dp = e.dp;
            end
            vectors++;
            if (index !== 2'(s)) begin
                miscompares++;
                $display("FAIL index slot%0d cyc%0d: got %0d, expected %0d", s, c, index, s);
            end
            vectors++;
            if (an !== exp_an) begin
                miscompares++;
                $display("FAIL an slot%0d cyc%0d: got %b, expected %b", s, c, an, exp_an);
            end
            vectors++;
            if (seg !== exp_seg) begin
                miscompares++;
                $display("FAIL seg slot%0d cyc%0d: got %h, expected %h", s, c, seg, exp_seg);
            end
            vectors++;
            if (dp !== exp_dp) begin
                miscompares++;
                $display("FAIL dp slot%0d cyc%0d: got %b, expected %b", s, c, dp, exp_dp);
            end
            vectors++;
            if (frame_done !== exp_fd) begin
                miscompares++;
                $display("FAIL frame_done slot%0d cyc%0d: got %b, expected %b", s, c, frame_done, exp_fd);
            end
            tick();
        end
        prev_seg = e.seg;
        prev_dp  = e.dp;
        if (s == 0) frame_seen = 1'b0;
        if (s == 3) frame_seen = 1'b1;
    endtask

    task automatic run_frame();
        for (int s = 0; s < 4; s++)
            check_slot(s);
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; dp_mask = 4'h0;
        set_number(4'd1, 4'd2, 4'd3, 4'd4);
        repeat (2) tick();
        rst = 1'b0; en = 1'b1;
        repeat (13) tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_reset_values("reset_hold");
        end
        rst = 1'b0;
        q.delete();
        prev_seg = 7'h7F; prev_dp = 1'b1; frame_seen = 1'b0;
    endtask

    task automatic test_number_1234();
        set_number(4'd1, 4'd2, 4'd3, 4'd4);
        dp_mask = 4'h0;
        push_frame(7'h79, 7'h24, 7'h30, 7'h19, 4'h0);
        push_frame(7'h79, 7'h24, 7'h30, 7'h19, 4'h0);
        run_frame();
        run_frame();
    endtask

    task automatic test_leading_zero();
        set_number(4'd0, 4'd0, 4'd0, 4'd7);
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
        push_frame(7'h7F, 7'h7F, 7'h7F, 7'h78, 4'h0);
`else
        push_frame(7'h40, 7'h40, 7'h40, 7'h78, 4'h0);
`endif
        run_frame();
        set_number(4'd0, 4'd0, 4'd0, 4'd0);
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
        push_frame(7'h7F, 7'h7F, 7'h7F, 7'h40, 4'h0);
`else
        push_frame(7'h40, 7'h40, 7'h40, 7'h40, 4'h0);
`endif
        run_frame();
    endtask

    task automatic test_bad_digit_dp();
        set_number(4'hC, 4'hC, 4'hC, 4'hC);
        dp_mask = 4'b0010;
        push_frame(7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'b0010);
        run_frame();
    endtask

    task automatic test_enable();
        set_number(4'd1, 4'd2, 4'd3, 4'd4);
        dp_mask = 4'h0;
        push_frame(7'h79, 7'h24, 7'h30, 7'h19, 4'h0);
        check_slot(0);
        repeat (5) tick();
        vectors++;
        if (an !== 4'b1011 || index !== 2'd1) begin
            miscompares++;
            $display("FAIL en_pre_drop: got an=%b index=%0d, expected an=1011 index=1", an, index);
        end
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            vectors++;
            if (an !== 4'hF || index !== 2'd1 || seg !== 7'h24 || dp !== 1'b1 || frame_done !== 1'b0) begin
                miscompares++;
                $display("FAIL en_low cyc%0d: got an=%b index=%0d seg=%h dp=%b fd=%b, expected an=1111 index=1 seg=24 dp=1 fd=0",
                         i, an, index, seg, dp, frame_done);
            end
        end
        en = 1'b1;
        prev_seg = 7'h24; prev_dp = 1'b1;
        check_slot(1);
        check_slot(2);
        check_slot(3);
    endtask

    task automatic test_reset_mid_show();
        set_number(4'd1, 4'd2, 4'd3, 4'd4);
        push_frame(7'h79, 7'h24, 7'h30, 7'h19, 4'h0);
        check_slot(0);
        check_slot(1);
        repeat (4) tick();
        vectors++;
        if (an !== 4'b1101 || index !== 2'd2) begin
            miscompares++;
            $display("FAIL mid_show: got an=%b index=%0d, expected an=1101 index=2", an, index);
        end
        rst = 1'b1;
        tick();
        check_reset_values("reset_mid_show");
        rst = 1'b0;
        q.delete();
        prev_seg = 7'h7F; prev_dp = 1'b1; frame_seen = 1'b0;
        push_frame(7'h79, 7'h24, 7'h30, 7'h19, 4'h0);
        run_frame();
    endtask

    initial begin
        test_reset();
        test_number_1234();
        test_leading_zero();
        test_bad_digit_dp();
        test_enable();
        test_reset_mid_show();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seg_scan.md
# seg_scan

Time-multiplexed driver for a 4-digit common-anode seven-segment display. Sits directly downstream of the decimal digit extractor. It drives the extractor's 2-bit `index` select and consumes the returned 4-bit BCD `digit`. It steps through positions 0 (thousands, leftmost) to 3 (units, rightmost) and produces registered anode, segment and decimal-point outputs, with an anti-ghosting blank interval at the start of every digit slot.

## Interface
- `CLK_DIV`, 50000: clock cycles per digit slot; legal range 3..2^20.
- `DEAD`, 4: cycles with all anodes off at the start of each slot; legal range 1 ≤ DEAD < CLK_DIV.

- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: scan enable.
- `digit` in 4: BCD digit for the current `index`, combinational return from the extractor.
- `dp_mask` in 4: bit i lights the decimal point at position i.
- `index` out 2: digit position select to the extractor; 0 = thousands.
- `an` out 4: anodes, active-low; `an[3]` is leftmost.
- `seg` out 7: segments, active-low, `{g,f,e,d,c,b,a}`.
- `dp` out 1: decimal point, active-low.
- `frame_done` out 1: one-cycle pulse when a full 4-digit frame completes.

## Operation
- Slot counter `cnt` runs 0..CLK_DIV-1 while `en`=1. At CLK_DIV-1 it wraps to 0 and `index` increments modulo 4.
- States are a function of `cnt`:
  - DEAD (`cnt` < DEAD): `an`=4'b1111.
  - SHOW (`cnt` ≥ DEAD): `an` = ~(4'b1000 >> `index`).
- Segment load: on the edge leaving `cnt`=DEAD-1, `seg` and `dp` load from `digit` and `dp_mask[index]`. `index` has been stable since `cnt`=0, so `digit` is settled. `seg`/`dp` hold through SHOW and the next DEAD interval.
- Decode, active-low gfedcba:
  - 0→7'h40, 1→7'h79, 2→7'h24, 3→7'h30, 4→7'h19
  - 5→7'h12, 6→7'h02, 7→7'h78, 8→7'h00, 9→7'h10
  - 10..15→7'h3F (dash)
- `dp` = ~`dp_mask[index]`.
- `frame_done`=1 for exactly the one cycle after `index` wraps 3→0.
- `en`=0:
  - Next cycle: `cnt`→0, `an`→4'b1111.
  - `index`, `seg`, `dp` hold; `frame_done`=0.
  - Re-assertion starts a fresh slot at the held `index`, beginning with DEAD.
- `rst` has priority over `en` and takes effect at any point, including mid-SHOW.

## Timing
- Reset values: `index`=0, `cnt`=0, `an`=4'b1111, `seg`=7'h7F, `dp`=1, `frame_done`=0.
- All outputs are registered; there is no combinational path from `digit` to any output.
- Latency from `digit` to `seg`: loaded at the end of cycle `cnt`=DEAD-1, visible while `cnt`=DEAD, which is the first SHOW cycle.
- Per slot: `an` is off for exactly DEAD cycles and on for exactly CLK_DIV-DEAD cycles.
- Frame period: 4·CLK_DIV cycles.
- Changes to `digit` or `dp_mask` after the load edge take effect at the next slot.

## Configuration
- Macro: `SEG_SCAN_LEADING_ZERO_BLANK_EN`.
- Defined:
  - Internal flag `nz` clears on the `index`=0 load edge, then sets whenever a nonzero `digit` is loaded.
  - At `index` 0..2, a `digit`=0 loaded while `nz`=0 gives `seg`=7'h7F.
  - `index` 3 is always shown, so value 0 displays as a single "0".
  - `dp` is unaffected by blanking.
- Undefined: the flag logic is absent and every digit is decoded.

## Test plan
All scenarios use CLK_DIV=8, DEAD=2, with the extractor instantiated on `index`/`digit`.
- **Reset:** hold `rst` 3 cycles mid-scan → `an`=4'hF, `seg`=7'h7F, `dp`=1, `index`=0, `frame_done`=0 from the next cycle.
- **Number 1234, `dp_mask`=0:** each slot shows 2 cycles `an`=4'hF, then 6 cycles active.
  - Slot 0: `an`=4'b0111, `seg`=7'h79.
  - Slot 1: `an`=4'b1011, `seg`=7'h24.
  - Slot 2: `an`=4'b1101, `seg`=7'h30.
  - Slot 3: `an`=4'b1110, `seg`=7'h19.
  - `frame_done` pulses once every 32 cycles.
- **Number 7:**
  - With the macro: slots 0-2 `seg`=7'h7F, slot 3 `seg`=7'h78.
  - Without the macro: `seg`=7'h40, 7'h40, 7'h40, 7'h78.
  - Number 0 with the macro: only slot 3 shows 7'h40.
- **`en` dropped at `cnt`=5 of slot 1 for 10 cycles:** `an`=4'hF from the next cycle and `index` stays 1. After re-enable: 2 cycles dark, then `an`=4'b1011 for 6 cycles.
- **Bad digit and decimal point:** force `digit`=4'hC → `seg`=7'h3F. With `dp_mask`=4'b0010 → `dp`=0 only during SHOW and following DEAD of slot 1, 1 elsewhere.
- **Reset mid-SHOW of slot 2:** next cycle shows reset values. Scan restarts at `index` 0 with DEAD timing.
